// File: rtl/cg_merge_reg_bank.sv
// Multi-lane register bank with per-class clock-gate enables (shared or split per MERGE)
// and saturating gated-clock activity counters for comparing power between modes.

module cg_merge_lane #(
    parameter int unsigned             WIDTH     = 9,
    parameter logic [WIDTH-1:0]        COPY_MASK = WIDTH'(1),
    parameter int unsigned             COPY_SRC  = 3,
    parameter int unsigned             MERGE     = 1,
    parameter int unsigned             CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic             stat_clr_i,
    output logic [WIDTH-1:0] out_o,
    output logic             cg_en_a_o,
    output logic             cg_en_b_o,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o
);
    // A class with no members never needs its gate opened.
    localparam bit               HAS_A   = (COPY_MASK != {WIDTH{1'b1}});
    localparam bit               HAS_B   = (COPY_MASK != {WIDTH{1'b0}});
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             en_raw_a, en_raw_b, en_a, en_b;

    always_comb begin
        en_raw_b = valid_i | ~last_i;
        en_raw_a = (MERGE != 0) ? en_raw_b : valid_i;
        en_a     = HAS_A & en_raw_a;
        en_b     = HAS_B & en_raw_b;
    end

    // Gated flops must see the edge that applies the synchronous reset.
    assign cg_en_a_o = ~rst_ni | en_a;
    assign cg_en_b_o = ~rst_ni | en_b;

    // Class A recirculates out when gated with valid=0 so merged edges are harmless.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (COPY_MASK[i]) begin
                if (en_b) out_d[i] = valid_i ? in_i[i] : out_q[COPY_SRC];
            end else begin
                if (en_a) out_d[i] = valid_i ? in_i[i] : out_q[i];
            end
        end
    end

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (stat_clr_i) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (en_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
            if (en_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            out_q   <= out_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign out_o   = out_q;
    assign cnt_a_o = cnt_a_q;
    assign cnt_b_o = cnt_b_q;
endmodule

module cg_merge_reg_bank #(
    parameter int unsigned      WIDTH     = 9,
    parameter int unsigned      LANES     = 4,
    parameter logic [WIDTH-1:0] COPY_MASK = WIDTH'(1),
    parameter int unsigned      COPY_SRC  = 3,
    parameter int unsigned      MERGE     = 1,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [LANES*WIDTH-1:0] in_i,
    input  logic [LANES-1:0]       valid_i,
    input  logic [LANES-1:0]       last_i,
    input  logic                   stat_clr_i,
    output logic [LANES*WIDTH-1:0] out_o,
    output logic [LANES-1:0]       cg_en_a_o,
    output logic [LANES-1:0]       cg_en_b_o,
    output logic [LANES*CNT_W-1:0] cnt_a_o,
    output logic [LANES*CNT_W-1:0] cnt_b_o
);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cg_merge_lane #(
            .WIDTH    (WIDTH),
            .COPY_MASK(COPY_MASK),
            .COPY_SRC (COPY_SRC),
            .MERGE    (MERGE),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .in_i      (in_i[k*WIDTH +: WIDTH]),
            .valid_i   (valid_i[k]),
            .last_i    (last_i[k]),
            .stat_clr_i(stat_clr_i),
            .out_o     (out_o[k*WIDTH +: WIDTH]),
            .cg_en_a_o (cg_en_a_o[k]),
            .cg_en_b_o (cg_en_b_o[k]),
            .cnt_a_o   (cnt_a_o[k*CNT_W +: CNT_W]),
            .cnt_b_o   (cnt_b_o[k*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_cg_merge_reg_bank.sv
// Scoreboard bench: MERGE=0, MERGE=1 and a 4-bit-counter instance share one stimulus
// stream and are checked every cycle against a rule-level model.

module tb_cg_merge_reg_bank;
    localparam int W  = 9;
    localparam int L  = 4;
    localparam int DW = L * W;
    localparam logic [W-1:0] MASK = 9'h001;
    localparam int SRC = 3;

    typedef struct {
        logic [L-1:0][W-1:0]       o;
        logic [2:0][L-1:0]         ea, eb;
        logic [2:0][L-1:0][15:0]   ca, cb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, stat_clr;
    logic [DW-1:0] din;
    logic [L-1:0]  vld, lst;

    logic [DW-1:0] out0, out1, out2;
    logic [L-1:0]  ea0, eb0, ea1, eb1, ea2, eb2;
    logic [63:0]   ca0, cb0, ca1, cb1;
    logic [15:0]   ca2, cb2;

    cg_merge_reg_bank #(.MERGE(0), .CNT_W(16)) u_m0 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(din), .valid_i(vld), .last_i(lst),
        .stat_clr_i(stat_clr), .out_o(out0), .cg_en_a_o(ea0), .cg_en_b_o(eb0),
        .cnt_a_o(ca0), .cnt_b_o(cb0));
    cg_merge_reg_bank #(.MERGE(1), .CNT_W(16)) u_m1 (
        .clk_i(clk), .rst_ni(rst_n), .in_i(din), .valid_i(vld), .last_i(lst),
        .stat_clr_i(stat_clr), .out_o(out1), .cg_en_a_o(ea1), .cg_en_b_o(eb1),
        .cnt_a_o(ca1), .cnt_b_o(cb1));
    cg_merge_reg_bank #(.MERGE(0), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .in_i(din), .valid_i(vld), .last_i(lst),
        .stat_clr_i(stat_clr), .out_o(out2), .cg_en_a_o(ea2), .cg_en_b_o(eb2),
        .cnt_a_o(ca2), .cnt_b_o(cb2));

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    logic [L-1:0][W-1:0]     m_out;
    logic [2:0][L-1:0][15:0] m_ca, m_cb;

    task automatic cmp(input string n, input int m, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%h exp=%h t=%0t", n, m, got, exp, $time);
        end
    endtask

    // Build the expectation for the current cycle, then advance the model one edge.
    task automatic step(input bit chk);
        exp_t e;
        logic [L-1:0][W-1:0] nxt;
        logic ra, rb;
        e.o = m_out; e.ca = m_ca; e.cb = m_cb;
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < L; k++) begin
                rb = vld[k] | ~lst[k];
                ra = (m == 1) ? rb : vld[k];
                e.ea[m][k] = ~rst_n | ra;
                e.eb[m][k] = ~rst_n | rb;
                if (!rst_n || stat_clr) begin
                    m_ca[m][k] = 16'd0;
                    m_cb[m][k] = 16'd0;
                end else begin
                    if (ra && m_ca[m][k] < ((m == 2) ? 16'd15 : 16'hFFFF)) m_ca[m][k] = m_ca[m][k] + 16'd1;
                    if (rb && m_cb[m][k] < ((m == 2) ? 16'd15 : 16'hFFFF)) m_cb[m][k] = m_cb[m][k] + 16'd1;
                end
            end
        end
        for (int k = 0; k < L; k++) begin
            if (!rst_n)       nxt[k] = '0;
            else if (vld[k])  nxt[k] = din[k*W +: W];
            else if (!lst[k]) nxt[k] = (m_out[k] & ~MASK) | (m_out[k][SRC] ? MASK : '0);
            else              nxt[k] = m_out[k];
        end
        if (chk) q.push_back(e);
        m_out = nxt;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [DW-1:0]     ao[3];
        logic [L-1:0]      aea[3], aeb[3];
        logic [L-1:0][15:0] aca[3], acb[3];
        if (q.size() != 0) begin
            e = q.pop_front();
            ao[0] = out0; ao[1] = out1; ao[2] = out2;
            aea[0] = ea0; aea[1] = ea1; aea[2] = ea2;
            aeb[0] = eb0; aeb[1] = eb1; aeb[2] = eb2;
            aca[0] = ca0; aca[1] = ca1; acb[0] = cb0; acb[1] = cb1;
            for (int k = 0; k < L; k++) begin
                aca[2][k] = {12'd0, ca2[k*4 +: 4]};
                acb[2][k] = {12'd0, cb2[k*4 +: 4]};
            end
            for (int m = 0; m < 3; m++) begin
                cmp("out", m, 64'(ao[m]), 64'(e.o));
                cmp("cg_en_a", m, 64'(aea[m]), 64'(e.ea[m]));
                cmp("cg_en_b", m, 64'(aeb[m]), 64'(e.eb[m]));
                cmp("cnt_a", m, 64'(aca[m]), 64'(e.ca[m]));
                cmp("cnt_b", m, 64'(acb[m]), 64'(e.cb[m]));
            end
        end
    end

    initial begin
        logic [DW-1:0] snap;
        logic [63:0]   csnap;
        rst_n = 1'b0; stat_clr = 1'b0; vld = '1; lst = '0; din = '1;
        step(0);
        repeat (3) step(1);
        cmp("rst_out", 0, 64'(out0), 64'd0);
        cmp("rst_cnt", 0, ca0 | cb0, 64'd0);

        rst_n = 1'b1; vld = '0; lst = '1; din = '0;
        step(1);
        vld = 4'b0001; din[8:0] = 9'h108;
        step(1);
        cmp("load_lane0", 0, 64'(out0[8:0]), 64'h108);
        vld = '0; lst = 4'b1110;
        step(1);
        cmp("copy_lane0", 0, 64'(out0[8:0]), 64'h109);
        lst = '1;
        step(1);
        cmp("hold_lane0", 0, 64'(out0[8:0]), 64'h109);

        snap = out0; csnap = ca0;
        vld = 4'b0100; din = '0; din[26:18] = 9'h1FF;
        step(1);
        cmp("indep_lane2", 0, 64'(out0[26:18]), 64'h1FF);
        cmp("indep_others", 0, 64'({out0[35:27], out0[17:0]}), 64'({snap[35:27], snap[17:0]}));
        vld = '0;
        step(1);
        cmp("indep_cnt", 0, {ca0[63:48], ca0[31:0]}, {csnap[63:48], csnap[31:0]});

        vld = '1;
        repeat (20) begin
            din = DW'({$urandom, $urandom});
            step(1);
        end
        cmp("sat_cnt_a", 2, 64'(ca2), 64'hFFFF);
        stat_clr = 1'b1;
        step(1);
        cmp("clr_cnt_a", 2, 64'(ca2[3:0]), 64'd0);
        stat_clr = 1'b0;
        step(1);
        cmp("post_clr_cnt_a", 2, 64'(ca2[3:0]), 64'd1);

        din = DW'({$urandom, $urandom});
        step(1);
        rst_n = 1'b0; din = DW'({$urandom, $urandom});
        step(1);
        cmp("midrst_out", 0, 64'(out0), 64'd0);
        cmp("midrst_cnt", 0, ca0 | cb0, 64'd0);
        rst_n = 1'b1;

        repeat (1000) begin
            vld      = L'($urandom);
            lst      = L'($urandom);
            din      = DW'({$urandom, $urandom});
            stat_clr = ($urandom_range(63) == 0);
            rst_n    = ($urandom_range(127) != 0);
            step(1);
        end
        rst_n = 1'b1; stat_clr = 1'b0; vld = '0; lst = '1;
        step(1);
        for (int k = 0; k < L; k++) begin
            checks++;
            if (ca1[k*16 +: 16] < ca0[k*16 +: 16]) begin
                errors++;
                $display("FAIL merge_cnt_ge lane%0d merged=%0d split=%0d", k, ca1[k*16 +: 16], ca0[k*16 +: 16]);
            end
        end
        repeat (2) @(posedge clk);
        cmp("queue_drained", 0, 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
